// File: rtl/dpcd_ratio_ctrl.sv
// rtl/dpcd_ratio_ctrl.sv - round-robin sharing of a programmable clock divider control word with settle hold
// Optional feature macro: DPCD_RATIO_CTRL_RAMP_EN (step div_ctrl by +/-1 toward the target)
module dpcd_ratio_ctrl #(
  parameter int DIV_CTRL_SIZE_P = 4,
  parameter int NUM_REQ_P       = 3,
  parameter int SETTLE_CYCLES_P = 32,
  localparam int OWNER_W_LP     = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1
) (
  input  logic                                 clk_src,
  input  logic                                 rst_n,
  input  logic [NUM_REQ_P-1:0]                 req,
  input  logic [NUM_REQ_P*DIV_CTRL_SIZE_P-1:0] req_div,
  output logic [NUM_REQ_P-1:0]                 ack,
  output logic [DIV_CTRL_SIZE_P-1:0]           div_ctrl,
  output logic                                 busy,
  output logic [OWNER_W_LP-1:0]                owner
);

  localparam int W_LP   = DIV_CTRL_SIZE_P;
  localparam int CNT_LP = (SETTLE_CYCLES_P > 2) ? $clog2(SETTLE_CYCLES_P) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_LP-1:0]      cnt_q, cnt_d;
  logic [W_LP-1:0]        div_q, div_d;
  logic [W_LP-1:0]        target_q, target_d;
  logic [OWNER_W_LP-1:0]  owner_q, owner_d;
  logic [OWNER_W_LP-1:0]  rr_q, rr_d;
  logic [NUM_REQ_P-1:0]   ack_q, ack_d;
  logic                   busy_q, busy_d;

  logic                   gnt_valid;
  logic [OWNER_W_LP-1:0]  gnt_idx;
  logic [W_LP-1:0]        gnt_div;
  logic [W_LP-1:0]        step_div;
  int                     srch_idx;

  // Round-robin search starting just above the last grantee
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_div   = '0;
    srch_idx  = 0;
    for (int i = 1; i <= NUM_REQ_P; i++) begin
      srch_idx = (int'(rr_q) + i) % NUM_REQ_P;
      if (!gnt_valid && req[srch_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = OWNER_W_LP'(srch_idx);
        gnt_div   = req_div[srch_idx*W_LP +: W_LP];
      end
    end
  end

  // Value written to the divider on the next STEP->SETTLE transition
`ifdef DPCD_RATIO_CTRL_RAMP_EN
  localparam logic [W_LP-1:0] TWO_LP = W_LP'(2);
  always_comb begin
    step_div = target_q;
    // Codes 0 and 1 are bypass/inverted clocks, so ramping through them makes no sense
    if (div_q >= TWO_LP && target_q >= TWO_LP) begin
      if (div_q < target_q) begin
        step_div = div_q + W_LP'(1);
      end else begin
        step_div = div_q - W_LP'(1);
      end
    end
  end
`else
  always_comb begin
    step_div = target_q;
  end
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    target_d = target_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d  = gnt_idx;
          target_d = gnt_div;
          state_d  = STEP;
        end
      end
      STEP: begin
        if (div_q == target_q) begin
          state_d = ACK;
        end else begin
          div_d   = step_div;
          cnt_d   = CNT_LP'(SETTLE_CYCLES_P - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = STEP;
        end else begin
          cnt_d = cnt_q - CNT_LP'(1);
        end
      end
      ACK: begin
        rr_d    = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ack_d = '0;
    if (state_d == ACK) begin
      ack_d[owner_d] = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset parks the divider in bypass with requester 0 first
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      target_q <= '0;
      owner_q  <= '0;
      rr_q     <= OWNER_W_LP'(NUM_REQ_P - 1);
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      target_q <= target_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign div_ctrl = div_q;
  assign busy     = busy_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_dpcd_ratio_ctrl.sv
// tb/tb_dpcd_ratio_ctrl.sv - directed self-checking bench for dpcd_ratio_ctrl (default parameters)
module tb_dpcd_ratio_ctrl;

  logic        clk_src = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [11:0] req_div;
  logic [2:0]  ack;
  logic [3:0]  div_ctrl;
  logic        busy;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;

  dpcd_ratio_ctrl dut (
    .clk_src  (clk_src),
    .rst_n    (rst_n),
    .req      (req),
    .req_div  (req_div),
    .ack      (ack),
    .div_ctrl (div_ctrl),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk_src = ~clk_src;

  // Raise one request, count negedges until ack, then drop it and step into IDLE
  task automatic do_txn(input int idx, input logic [3:0] val, output int cycles,
                        output logic [2:0] ack_v, output int changes);
    logic [3:0] prev;
    cycles  = -1;
    ack_v   = '0;
    changes = 0;
    prev    = div_ctrl;
    req_div[idx*4 +: 4] = val;
    req[idx] = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk_src);
      if (div_ctrl !== prev) begin
        changes++;
        prev = div_ctrl;
      end
      if (ack !== 3'b000) begin
        cycles = i;
        ack_v  = ack;
        break;
      end
    end
    req[idx] = 1'b0;
    @(negedge clk_src);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; req = '0; req_div = '0;
    repeat (3) @(negedge clk_src);
    rst_n = 1'b1;
    @(negedge clk_src);
    checks++; if (div_ctrl !== 4'd0) begin errors++; $display("FAIL reset_div: got %0d expected 0", div_ctrl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    bad = 0;
    repeat (100) begin
      @(negedge clk_src);
      if (div_ctrl !== 4'd0 || busy !== 1'b0 || ack !== 3'b000 || owner !== 2'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_idle_stable: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_single();
    int cycles, hold_bad;
    logic [2:0] ack_v;
    cycles = -1; hold_bad = 0; ack_v = '0;
    req_div[7:4] = 4'd6;
    req[1] = 1'b1;
    @(negedge clk_src);
    checks++; if (busy !== 1'b1 || owner !== 2'd1) begin errors++; $display("FAIL single_grant: got busy=%b owner=%0d expected busy=1 owner=1", busy, owner); end
    @(negedge clk_src);
    checks++; if (div_ctrl !== 4'd6) begin errors++; $display("FAIL single_div_k1: got %0d expected 6", div_ctrl); end
    for (int i = 3; i <= 400; i++) begin
      @(negedge clk_src);
      if (div_ctrl !== 4'd6) hold_bad++;
      if (ack !== 3'b000) begin
        cycles = i;
        ack_v  = ack;
        break;
      end
    end
    req[1] = 1'b0;
    checks++; if (cycles !== 35) begin errors++; $display("FAIL single_ack_time: got %0d expected 35", cycles); end
    checks++; if (ack_v !== 3'b010) begin errors++; $display("FAIL single_ack_bit: got %b expected 010", ack_v); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL single_div_hold: got %0d bad cycles expected 0", hold_bad); end
    @(negedge clk_src);
    checks++; if (busy !== 1'b0 || ack !== 3'b000) begin errors++; $display("FAIL single_after_ack: got busy=%b ack=%b expected 0 000", busy, ack); end
  endtask

  task automatic test_ramp();
    int cycles, changes, exp_c1, exp_n1, exp_c2, exp_n2;
    logic [2:0] ack_v;
`ifdef DPCD_RATIO_CTRL_RAMP_EN
    exp_c1 = 68;  exp_n1 = 2;
    exp_c2 = 101; exp_n2 = 3;
`else
    exp_c1 = 35;  exp_n1 = 1;
    exp_c2 = 35;  exp_n2 = 1;
`endif
    do_txn(0, 4'd4, cycles, ack_v, changes);
    checks++; if (cycles !== exp_c1 || changes !== exp_n1 || div_ctrl !== 4'd4) begin errors++; $display("FAIL ramp_6_to_4: got t=%0d n=%0d div=%0d expected t=%0d n=%0d div=4", cycles, changes, div_ctrl, exp_c1, exp_n1); end
    do_txn(2, 4'd7, cycles, ack_v, changes);
    checks++; if (cycles !== exp_c2 || changes !== exp_n2) begin errors++; $display("FAIL ramp_4_to_7_time: got t=%0d n=%0d expected t=%0d n=%0d", cycles, changes, exp_c2, exp_n2); end
    checks++; if (ack_v !== 3'b100 || div_ctrl !== 4'd7) begin errors++; $display("FAIL ramp_4_to_7_result: got ack=%b div=%0d expected 100 7", ack_v, div_ctrl); end
    do_txn(0, 4'd0, cycles, ack_v, changes);
    checks++; if (cycles !== 35 || changes !== 1 || div_ctrl !== 4'd0) begin errors++; $display("FAIL ramp_7_to_0_jump: got t=%0d n=%0d div=%0d expected t=35 n=1 div=0", cycles, changes, div_ctrl); end
  endtask

  task automatic test_equal();
    int cycles, changes;
    logic [2:0] ack_v;
    do_txn(1, 4'd5, cycles, ack_v, changes);
    checks++; if (cycles !== 35 || div_ctrl !== 4'd5) begin errors++; $display("FAIL equal_setup: got t=%0d div=%0d expected t=35 div=5", cycles, div_ctrl); end
    do_txn(1, 4'd5, cycles, ack_v, changes);
    checks++; if (cycles !== 2 || changes !== 0) begin errors++; $display("FAIL equal_fast_ack: got t=%0d n=%0d expected t=2 n=0", cycles, changes); end
    checks++; if (ack_v !== 3'b010 || div_ctrl !== 4'd5 || busy !== 1'b0) begin errors++; $display("FAIL equal_result: got ack=%b div=%0d busy=%b expected 010 5 0", ack_v, div_ctrl, busy); end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [4];
    int found;
    rst_n = 1'b0;
    @(negedge clk_src);
    rst_n = 1'b1;
    req_div = {4'd5, 4'd5, 4'd5};
    req = 3'b111;
    found = 0;
    for (int i = 0; i < 2000 && found < 4; i++) begin
      @(negedge clk_src);
      if (ack !== 3'b000) begin
        order[found] = ack;
        if (found == 2) req = 3'b101;
        else req = req & ~ack;
        found++;
      end
    end
    req = '0;
    @(negedge clk_src);
    checks++; if (found !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d expected 4", found); end
    else begin
      checks++; if (order[0] !== 3'b001 || order[1] !== 3'b010 || order[2] !== 3'b100) begin errors++; $display("FAIL rr_order: got %b %b %b expected 001 010 100", order[0], order[1], order[2]); end
      checks++; if (order[3] !== 3'b001) begin errors++; $display("FAIL rr_wrap_priority: got %b expected 001", order[3]); end
    end
  endtask

  task automatic test_reset_mid();
    int cycles, ack_cnt;
    logic [2:0] ack_v;
    cycles = -1; ack_v = '0; ack_cnt = 0;
    req_div[7:4] = 4'd9;
    req[1] = 1'b1;
    repeat (12) @(negedge clk_src);
    checks++; if (div_ctrl !== 4'd9 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_in_settle: got div=%0d busy=%b expected 9 1", div_ctrl, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (div_ctrl !== 4'd0 || busy !== 1'b0 || ack !== 3'b000 || owner !== 2'd0) begin errors++; $display("FAIL rstmid_immediate: got div=%0d busy=%b ack=%b owner=%0d expected 0 0 000 0", div_ctrl, busy, ack, owner); end
    repeat (2) begin
      @(negedge clk_src);
      if (ack !== 3'b000) ack_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk_src);
      if (ack !== 3'b000) begin
        cycles = i;
        ack_v  = ack;
        break;
      end
    end
    req[1] = 1'b0;
    @(negedge clk_src);
    checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", ack_cnt); end
    checks++; if (cycles !== 35 || ack_v !== 3'b010 || div_ctrl !== 4'd9) begin errors++; $display("FAIL rstmid_regrant: got t=%0d ack=%b div=%0d expected t=35 ack=010 div=9", cycles, ack_v, div_ctrl); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ramp();
    test_equal();
    test_round_robin();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
